// File: rtl/ahb_sram_responder.sv
// ----------------------------------------------------------------------------
// ahb_sram_responder
//   AHB slave backed by a word-organised SRAM. It accepts address phases when
//   selected and the bus is ready, then answers with a configurable number of
//   wait states followed by OKAY. Misaligned, oversized or out-of-window
//   transfers get a two-cycle ERROR and never touch the SRAM.
//
// Ports
//   hclk, hreset_n   bus clock, asynchronous active-low reset
//   hsel             slot select from the address decoder
//   haddr, htrans    transfer address and type (IDLE/BUSY/NONSEQ/SEQ)
//   hwrite, hsize    direction and size (byte/halfword/word)
//   hburst, hprot,   accepted for interface completeness; no effect
//   hmastlock
//   hwdata           write data, valid during the data phase
//   hready           bus-wide ready (muxed hreadyout of the active slave)
//   hreadyout        this responder's ready
//   hresp            00 OKAY, 01 ERROR
//   hrdata           read data, valid while hreadyout = 1 in the data phase
// ----------------------------------------------------------------------------
module ahb_sram_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          MEM_ADDR_W  = 10,
  parameter int          WAIT_STATES = 1
) (
  input  logic        hclk,
  input  logic        hreset_n,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  input  logic        hmastlock,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata
);

  localparam int IDX_W = MEM_ADDR_W - 2;
  localparam int WORDS = 2 ** IDX_W;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  logic [2:0]       state;
  logic [3:0]       wait_cnt;
  logic [IDX_W-1:0] idx_q;     // word index of the transfer in its data phase
  logic [3:0]       be_q;      // byte lanes of that transfer
  logic             write_q;

  logic [31:0]      mem [WORDS];

  logic             accept;
  logic             xfer_err;
  logic             commit;
  logic [IDX_W-1:0] rd_idx;
  logic [3:0]       be_d;
  logic [31:0]      rd_word;

  // Burst type, protection, lock and the SEQ/NONSEQ distinction do not
  // change how a beat is handled.
  logic unused_inputs;
  assign unused_inputs = ^{hburst, hprot, hmastlock, htrans[0]};

  // The states that drive hreadyout high are exactly those in which a new
  // address phase may be taken; while stalled the bus hready is low anyway.
  assign hreadyout = (state != ST_WAIT) && (state != ST_ERR1);
  assign hresp     = ((state == ST_ERR1) || (state == ST_ERR2)) ? 2'b01 : 2'b00;

  assign accept = hsel && hready && htrans[1] && hreadyout;
  assign rd_idx = haddr[MEM_ADDR_W-1:2];
  assign commit = (state == ST_DATA) && write_q;

  assign xfer_err = (haddr[31:MEM_ADDR_W] != BASE_ADDR[31:MEM_ADDR_W])
                 || (hsize > 3'b010)
                 || ((hsize == 3'b001) && haddr[0])
                 || ((hsize == 3'b010) && (haddr[1:0] != 2'b00));

  // Little-endian byte lanes for the accepted transfer.
  // NOTE: every signal written in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    be_d = 4'b1111;
    case (hsize)
      3'b000:  be_d = 4'b0001 << haddr[1:0];
      3'b001:  be_d = haddr[1] ? 4'b1100 : 4'b0011;
      default: be_d = 4'b1111;
    endcase
  end

  // A read accepted on the edge that commits a write to the same word must
  // see the freshly written bytes, so merge them in ahead of the array.
  always_comb begin
    rd_word = mem[rd_idx];
    if (commit && (idx_q == rd_idx)) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) rd_word[8*b +: 8] = hwdata[8*b +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      idx_q    <= '0;
      be_q     <= 4'b0000;
      write_q  <= 1'b0;
      hrdata   <= 32'h0;
    end else begin
      case (state)
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) state <= ST_DATA;
        end
        ST_ERR1: state <= ST_ERR2;
        default: begin
          // IDLE, DATA and ERR2 can all take the next pipelined address phase.
          if (accept) begin
            idx_q   <= rd_idx;
            be_q    <= be_d;
            write_q <= hwrite;
            if (xfer_err) begin
              state <= ST_ERR1;
            end else begin
              if (!hwrite) hrdata <= rd_word;
              if (WAIT_STATES == 0) begin
                state <= ST_DATA;
              end else begin
                state    <= ST_WAIT;
                wait_cnt <= 4'(WAIT_STATES);
              end
            end
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // NOTE: the SRAM array has no reset; its contents survive hreset_n and a
  // pending write is dropped because reset forces the state out of DATA.
  always_ff @(posedge hclk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/ahb_sram_responder.md
Name: ahb_sram_responder

Overview:
AHB responder (slave) backed by a word-organised on-chip SRAM. It is one of the slave slots behind the address decoder and the slave-side multiplexer. It accepts address phases from whichever master the arbiter has granted and completes data phases with a configurable number of wait states. It returns OKAY, or a two-cycle ERROR for transfers it must not perform.

Parameters:
BASE_ADDR, 32'h0000_0000, base of the responder window; haddr[31:MEM_ADDR_W] must equal BASE_ADDR[31:MEM_ADDR_W]
MEM_ADDR_W, 10, byte-address width of the SRAM (2**MEM_ADDR_W bytes, 32-bit words)
WAIT_STATES, 1, number of hreadyout-low cycles inserted before each OKAY data phase (0..15)

Ports:
hclk  input  1  bus clock; all state changes on the rising edge
hreset_n  input  1  asynchronous active-low reset
hsel  input  1  slot select from the address decoder
haddr  input  32  transfer address
htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
hwrite  input  1  1 = write
hsize  input  3  000 byte, 001 halfword, 010 word
hburst  input  3  burst type (informational only; addresses are taken from haddr every beat)
hprot  input  4  protection (ignored)
hmastlock  input  1  locked sequence (ignored; no effect on responses)
hwdata  input  32  write data, valid in the data phase
hready  input  1  bus-wide ready (muxed hreadyout of the active slave)
hreadyout  output  1  this responder's ready
hresp  output  2  00 OKAY, 01 ERROR; RETRY and SPLIT are never issued
hrdata  output  32  read data

Behaviour:
- Reset (async assert, sync release) values:
  - state = IDLE, hreadyout = 1, hresp = 00, hrdata = 0, wait counter = 0.
  - SRAM contents are not cleared.
  - A pending write is dropped.
- Address phase is accepted on a rising edge when hsel & hready & htrans[1]. At that edge the responder registers haddr, hsize and hwrite.
- The address phase is ignored (next cycle is a zero-wait OKAY) in any of these cases:
  - htrans = IDLE or BUSY with hsel & hready;
  - hsel = 0;
  - hready = 0 (another slave is stalling).
- Error check at acceptance. ERROR if any of:
  - haddr[31:MEM_ADDR_W] != BASE_ADDR[31:MEM_ADDR_W];
  - hsize > 010;
  - halfword with haddr[0] = 1;
  - word with haddr[1:0] != 00.
  An errored transfer never touches the SRAM.
- States:
  - IDLE: hreadyout = 1, OKAY.
  - WAIT: hreadyout = 0, OKAY; counter counts down from WAIT_STATES; goes to DATA when the counter reaches 1.
  - DATA: hreadyout = 1, OKAY; transfer completes here.
  - ERR1: hreadyout = 0, hresp = 01.
  - ERR2: hreadyout = 1, hresp = 01.
- Transitions on accept:
  - error → ERR1;
  - else WAIT_STATES = 0 → DATA;
  - else → WAIT.
- ERR1 always goes to ERR2.
- From IDLE, DATA and ERR2: a new accept follows the rules above; otherwise go to IDLE. Back-to-back pipelined transfers are therefore supported at full rate when WAIT_STATES = 0.
- Reads:
  - The SRAM word is read at the accepting edge into hrdata.
  - hrdata is valid only while hreadyout = 1 in DATA; it holds its value otherwise.
  - Byte and halfword reads return the full word; the master selects the lanes (little-endian).
- Writes:
  - hwdata is written at the edge that ends DATA.
  - Byte enables come from hsize/haddr[1:0] (little-endian lanes). Unselected bytes are unchanged.
- Read-after-write bypass: if a read is accepted on the same edge that commits a write to the same word, hrdata = old word with the written bytes replaced by hwdata.
- Mid-burst address changes and hburst values do not affect behaviour; each beat is checked independently.
- Reset mid-transfer: the response aborts immediately to the reset values.

Test Plan:
1. WAIT_STATES = 1: word write NONSEQ 0x000 = 0xDEADBEEF, then read 0x000 → one hreadyout-low cycle each, hresp = 00, hrdata = 0xDEADBEEF.
2. WAIT_STATES = 0: write byte 0x55 to 0x003, then read word 0x000 pipelined in the next address phase → no stall, hrdata = 0x55ADBEEF (bypass).
3. Word access at 0x002 → ERR1 (hreadyout = 0, hresp = 01) then ERR2 (hreadyout = 1, hresp = 01); SRAM unchanged on readback.
4. Address 0x0000_0400 with MEM_ADDR_W = 10, and hsize = 011 at 0x000 → both two-cycle ERROR.
5. INCR4 burst with a BUSY between beats 2 and 3 → BUSY gets a zero-wait OKAY; 4 beats stored correctly; hsel = 0 with hready = 0 → no response change.
6. Assert hreset_n = 0 during WAIT → hreadyout = 1, hresp = 00, hrdata = 0 immediately; the pending write is not performed.
